// File: rtl/mem_arb_pkg.sv
// Shared definitions for the SPRAM slot arbiter: video FSM state encoding
// and the fixed slot / address-bit positions of the CPU access window.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        VADDR = 2'd1,
        VDATA = 2'd2
    } vid_state_e;

    localparam int CPU_SLOT       = 0;
    localparam int CPU_RDATA_SLOT = 2;
    localparam int RAM_WINDOW_BIT = 15;

endpackage

// File: rtl/mem_slot_timer.sv
// Slot counter dividing dot_clk into CPU cycles of SLOTS slots, plus the
// registered cpu_clk (low in the first half of the cycle, high in the second).
module mem_slot_timer
    import mem_arb_pkg::*;
#(
    parameter int SLOTS = 4
) (
    input  logic                     dot_clk,
    input  logic                     reset,
    output logic [$clog2(SLOTS)-1:0] slot,
    output logic [$clog2(SLOTS)-1:0] slot_next,
    output logic                     cpu_clk
);

    localparam int SW = $clog2(SLOTS);

    if (SLOTS < 4 || SLOTS > 16 || (SLOTS % 2) != 0) begin : g_bad_slots
        $error("mem_slot_timer: SLOTS must be even and within 4..16");
    end

    logic [SW-1:0] r_slot;
    logic          r_cpu_clk;
    logic [SW-1:0] w_slot_next;

    always_comb begin
        if (r_slot == SW'(SLOTS - 1)) begin
            w_slot_next = '0;
        end else begin
            w_slot_next = r_slot + 1'b1;
        end
    end

    // cpu_clk follows the slot being entered so it changes together with r_slot
    always_ff @(posedge dot_clk) begin
        if (reset) begin
            r_slot    <= '0;
            r_cpu_clk <= 1'b0;
        end else begin
            r_slot    <= w_slot_next;
            r_cpu_clk <= (w_slot_next >= SW'(SLOTS / 2));
        end
    end

    assign slot      = r_slot;
    assign slot_next = w_slot_next;
    assign cpu_clk   = r_cpu_clk;

endmodule

// File: rtl/mem_slot_arbiter.sv
// Time-division owner of the shared SPRAM: slot 0 serves the CPU, other slots
// serve video reads. Optional MEM_ARB_STATS_EN adds the vid_stall_count output.
module mem_slot_arbiter #(
    parameter int SLOTS  = 4,
    parameter int ADDR_W = 15,
    parameter int DATA_W = 8
) (
    input  logic              dot_clk,
    input  logic              reset,
    output logic              cpu_clk,
    input  logic [15:0]       cpu_addr,
    input  logic [DATA_W-1:0] cpu_data_in,
    input  logic              cpu_write_enable,
    output logic [DATA_W-1:0] cpu_data_out,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_ack,
    output logic [DATA_W-1:0] vid_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [15:0]       vid_stall_count
`endif
);
    import mem_arb_pkg::*;

    localparam int SW = $clog2(SLOTS);

    logic [SW-1:0]     w_slot;
    logic [SW-1:0]     w_slot_next;
    logic              w_enter_cpu;
    logic              w_cpu_rdata;
    logic              w_grant;

    vid_state_e        r_state;
    logic              r_vid_ack;
    logic [DATA_W-1:0] r_vid_data;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_mem_we;
    logic [DATA_W-1:0] r_cpu_data_out;

    mem_slot_timer #(
        .SLOTS(SLOTS)
    ) u_timer (
        .dot_clk   (dot_clk),
        .reset     (reset),
        .slot      (w_slot),
        .slot_next (w_slot_next),
        .cpu_clk   (cpu_clk)
    );

    assign w_enter_cpu = (w_slot_next == SW'(CPU_SLOT));
    // During the slot before CPU_RDATA_SLOT the RAM output holds the CPU read data
    assign w_cpu_rdata = (w_slot == SW'(CPU_RDATA_SLOT - 1));
    // No grant in the ack cycle, so a requester may update vid_addr/vid_req there
    assign w_grant     = (r_state == IDLE) && vid_req && !r_vid_ack && !w_enter_cpu;

    always_ff @(posedge dot_clk) begin
        if (reset) begin
            r_mem_addr     <= '0;
            r_mem_wdata    <= '0;
            r_mem_we       <= 1'b0;
            r_cpu_data_out <= '0;
        end else begin
            if (w_enter_cpu) begin
                r_mem_addr  <= cpu_addr[ADDR_W-1:0];
                r_mem_wdata <= cpu_data_in;
                r_mem_we    <= cpu_write_enable & ~cpu_addr[RAM_WINDOW_BIT];
            end else begin
                r_mem_we <= 1'b0;
                if (w_grant) begin
                    r_mem_addr <= vid_addr;
                end
            end
            if (w_cpu_rdata) begin
                r_cpu_data_out <= mem_rdata;
            end
        end
    end

    // The RAM registers the previous cycle's address, so VDATA sees the video
    // data even when it lands in the CPU slot.
    always_ff @(posedge dot_clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_vid_ack  <= 1'b0;
            r_vid_data <= '0;
        end else begin
            r_vid_ack <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_state <= VADDR;
                    end
                end
                VADDR: begin
                    r_state <= VDATA;
                end
                VDATA: begin
                    r_state    <= IDLE;
                    r_vid_data <= mem_rdata;
                    r_vid_ack  <= 1'b1;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef MEM_ARB_STATS_EN
    logic [15:0] r_stall_count;

    always_ff @(posedge dot_clk) begin
        if (reset) begin
            r_stall_count <= '0;
        end else if (vid_req && (r_state == IDLE) && !r_vid_ack && w_enter_cpu &&
                     (r_stall_count != 16'hFFFF)) begin
            r_stall_count <= r_stall_count + 16'd1;
        end
    end

    assign vid_stall_count = r_stall_count;
`endif

    assign cpu_data_out = r_cpu_data_out;
    assign vid_ack      = r_vid_ack;
    assign vid_data     = r_vid_data;
    assign mem_addr     = r_mem_addr;
    assign mem_wdata    = r_mem_wdata;
    assign mem_we       = r_mem_we;

endmodule

// File: tb/tb_mem_slot_arbiter.sv
// Bench for mem_slot_arbiter: directed CPU vector table, video corner-case
// sequences and a randomized run against a transaction-level model.
`timescale 1ns/1ps
module tb_mem_slot_arbiter;

    localparam int S  = 4;
    localparam int AW = 15;
    localparam int DW = 8;

    logic          dot_clk = 1'b0;
    logic          reset;
    logic          cpu_clk;
    logic [15:0]   cpu_addr;
    logic [DW-1:0] cpu_data_in;
    logic          cpu_write_enable;
    logic [DW-1:0] cpu_data_out;
    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic          vid_ack;
    logic [DW-1:0] vid_data;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [DW-1:0] mem_rdata;
`ifdef MEM_ARB_STATS_EN
    logic [15:0]   vid_stall_count;
`endif

    always #5 dot_clk = ~dot_clk;

    mem_slot_arbiter #(.SLOTS(S), .ADDR_W(AW), .DATA_W(DW)) dut (
        .dot_clk          (dot_clk),
        .reset            (reset),
        .cpu_clk          (cpu_clk),
        .cpu_addr         (cpu_addr),
        .cpu_data_in      (cpu_data_in),
        .cpu_write_enable (cpu_write_enable),
        .cpu_data_out     (cpu_data_out),
        .vid_req          (vid_req),
        .vid_addr         (vid_addr),
        .vid_ack          (vid_ack),
        .vid_data         (vid_data),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
        .mem_we           (mem_we),
        .mem_rdata        (mem_rdata)
`ifdef MEM_ARB_STATS_EN
        ,
        .vid_stall_count  (vid_stall_count)
`endif
    );

    function automatic logic [7:0] init_byte(input logic [14:0] a);
        return 8'hC3 ^ a[7:0];
    endfunction

    // Single-port SPRAM, registered address, read-before-write
    logic [DW-1:0] ram    [0:32767];
    bit            ram_wr [0:32767];
    always @(posedge dot_clk) begin
        if (mem_we) begin
            ram[mem_addr]    <= mem_wdata;
            ram_wr[mem_addr] <= 1'b1;
        end
        mem_rdata <= ram_wr[mem_addr] ? ram[mem_addr] : init_byte(mem_addr);
    end

    // Model of RAM contents as seen by the CPU program
    logic [7:0] shadow [0:32767];

    int n_chk  = 0;
    int n_pass = 0;
    int k      = 0;
    int exp_stall = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, k);
    endtask

    task automatic step();
        @(posedge dot_clk);
        #1;
        k++;
    endtask

    // Advance until the next edge enters slot s
    task automatic pre(input int s);
        for (int i = 0; i < S && ((k + 1) % S) != s; i++) step();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        k = 0;
        exp_stall = 0;
    endtask

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  din;
        logic        we;
        logic        exp_we;
        logic [14:0] exp_maddr;
        logic        chk_rd;
        logic [7:0]  exp_rd;
    } cpu_vec_t;

    cpu_vec_t vecs [7];

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [14:0] va;
        logic [14:0] pend_addr;
        logic [15:0] op_addr;
        logic [7:0]  op_din;
        logic [7:0]  g_data;
        logic        op_we, pend, granted, exp_ack, exp_we;
        int          req_cyc, g_edge, next_ok, slot;

        vecs[0] = '{16'h1234, 8'h5A, 1'b1, 1'b1, 15'h1234, 1'b0, 8'h00};
        vecs[1] = '{16'h1234, 8'h00, 1'b0, 1'b0, 15'h1234, 1'b1, 8'h5A};
        vecs[2] = '{16'h8400, 8'h77, 1'b1, 1'b0, 15'h0400, 1'b0, 8'h00};
        vecs[3] = '{16'h0400, 8'h00, 1'b0, 1'b0, 15'h0400, 1'b1, 8'hC3};
        vecs[4] = '{16'h7FFF, 8'hA5, 1'b1, 1'b1, 15'h7FFF, 1'b0, 8'h00};
        vecs[5] = '{16'h7FFF, 8'h00, 1'b0, 1'b0, 15'h7FFF, 1'b1, 8'hA5};
        vecs[6] = '{16'h8012, 8'h00, 1'b0, 1'b0, 15'h0012, 1'b1, 8'hD1};

        for (int i = 0; i < 32768; i++) shadow[i] = init_byte(15'(i));

        // Reset with busy inputs: every output must still come up zero
        cpu_addr = 16'h1234; cpu_data_in = 8'hA5; cpu_write_enable = 1'b1;
        vid_req = 1'b1; vid_addr = 15'h0055;
        do_reset();
        chk("rst_cpu_clk", 32'(cpu_clk), 32'(0));
        chk("rst_mem_addr", 32'(mem_addr), 32'(0));
        chk("rst_mem_wdata", 32'(mem_wdata), 32'(0));
        chk("rst_mem_we", 32'(mem_we), 32'(0));
        chk("rst_vid_ack", 32'(vid_ack), 32'(0));
        chk("rst_vid_data", 32'(vid_data), 32'(0));
        chk("rst_cpu_data_out", 32'(cpu_data_out), 32'(0));
`ifdef MEM_ARB_STATS_EN
        chk("rst_stall", 32'(vid_stall_count), 32'(0));
`endif
        vid_req = 1'b0; cpu_write_enable = 1'b0; cpu_addr = 16'h0000;

        for (int i = 0; i < 2 * S; i++) begin
            step();
            chk("cpu_clk_pattern", 32'(cpu_clk), 32'((k % S) >= S / 2));
        end

        // CPU vector table
        for (int i = 0; i < 7; i++) begin
            pre(0);
            cpu_addr = vecs[i].addr; cpu_data_in = vecs[i].din; cpu_write_enable = vecs[i].we;
            if (vecs[i].we && !vecs[i].addr[15]) shadow[vecs[i].addr[14:0]] = vecs[i].din;
            step();
            chk("tbl_mem_we", 32'(mem_we), 32'(vecs[i].exp_we));
            chk("tbl_mem_addr", 32'(mem_addr), 32'(vecs[i].exp_maddr));
            if (vecs[i].exp_we) chk("tbl_mem_wdata", 32'(mem_wdata), 32'(vecs[i].din));
            for (int s = 1; s < S; s++) begin
                step();
                chk("tbl_mem_we_off", 32'(mem_we), 32'(0));
                if (s == 2 && vecs[i].chk_rd)
                    chk("tbl_cpu_rdata", 32'(cpu_data_out), 32'(vecs[i].exp_rd));
            end
        end
        cpu_write_enable = 1'b0;

        // Single video read granted entering slot 1
        pre(1);
        vid_req = 1'b1; vid_addr = 15'h0100;
        step();
        chk("v1_grant_addr", 32'(mem_addr), 32'h0100);
        chk("v1_ack_early0", 32'(vid_ack), 32'(0));
        step();
        chk("v1_ack_early1", 32'(vid_ack), 32'(0));
        step();
        chk("v1_ack", 32'(vid_ack), 32'(1));
        chk("v1_data", 32'(vid_data), 32'(shadow[15'h0100]));
        vid_req = 1'b0;
        step();
        chk("v1_ack_pulse", 32'(vid_ack), 32'(0));

        // Continuous requests: one ack every 4 cycles, no duplicates
        pre(1);
        va = 15'h00A0;
        vid_req = 1'b1; vid_addr = va;
        for (int j = 0; j < 12; j++) begin
            step();
            chk("vc_ack", 32'(vid_ack), 32'((j % 4) == 2));
            if ((j % 4) == 0) chk("vc_grant_addr", 32'(mem_addr), 32'(va));
            if ((j % 4) == 2) begin
                chk("vc_data", 32'(vid_data), 32'(shadow[va]));
                va = va + 15'd1;
                vid_addr = va;
            end
        end
        vid_req = 1'b0;

        // Request landing on the CPU slot is deferred; CPU write unaffected
        do_reset();
        pre(0);
        vid_req = 1'b1; vid_addr = 15'h0200;
        cpu_addr = 16'h0300; cpu_data_in = 8'h11; cpu_write_enable = 1'b1;
        shadow[15'h0300] = 8'h11;
        step();
        exp_stall++;
        chk("def_cpu_addr", 32'(mem_addr), 32'h0300);
        chk("def_cpu_we", 32'(mem_we), 32'(1));
        chk("def_cpu_wdata", 32'(mem_wdata), 32'h11);
        cpu_write_enable = 1'b0;
        step();
        chk("def_grant_addr", 32'(mem_addr), 32'h0200);
        chk("def_we_off", 32'(mem_we), 32'(0));
        step();
        chk("def_ack_early", 32'(vid_ack), 32'(0));
        step();
        chk("def_ack", 32'(vid_ack), 32'(1));
        chk("def_data", 32'(vid_data), 32'(shadow[15'h0200]));
        vid_req = 1'b0;
`ifdef MEM_ARB_STATS_EN
        chk("def_stall", 32'(vid_stall_count), 32'(exp_stall));
`endif

        // Reset while in VADDR drops the request; a re-issue completes
        pre(1);
        vid_req = 1'b1; vid_addr = 15'h0040;
        step();
        chk("rv_grant_addr", 32'(mem_addr), 32'h0040);
        vid_req = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        k = 0;
        exp_stall = 0;
        chk("rv_ack", 32'(vid_ack), 32'(0));
        chk("rv_mem_addr", 32'(mem_addr), 32'(0));
        chk("rv_cpu_clk", 32'(cpu_clk), 32'(0));
        for (int i = 0; i < 6; i++) begin
            step();
            chk("rv_no_ack", 32'(vid_ack), 32'(0));
            chk("rv_cpu_clk_pat", 32'(cpu_clk), 32'((k % S) >= S / 2));
        end
        pre(1);
        vid_req = 1'b1; vid_addr = 15'h0040;
        step();
        chk("rv_regrant", 32'(mem_addr), 32'h0040);
        step();
        step();
        chk("rv_reack", 32'(vid_ack), 32'(1));
        chk("rv_redata", 32'(vid_data), 32'(shadow[15'h0040]));
        vid_req = 1'b0;
`ifdef MEM_ARB_STATS_EN
        chk("rv_stall", 32'(vid_stall_count), 32'(exp_stall));
`endif

        // Randomized run against a transaction-level model
        cpu_addr = 16'h0000; cpu_data_in = 8'h00; cpu_write_enable = 1'b0;
        vid_req = 1'b0; vid_addr = '0;
        do_reset();
        op_addr = 16'h0000; op_din = 8'h00; op_we = 1'b0;
        pend = 1'b0; granted = 1'b0; pend_addr = '0; g_data = '0;
        req_cyc = 0; g_edge = 0; next_ok = 0;
        for (int c = 0; c < 1200; c++) begin
            step();
            slot = k % S;
            chk("rnd_cpu_clk", 32'(cpu_clk), 32'(slot >= S / 2));
            if (pend && !granted && req_cyc < k && k >= next_ok) begin
                if (slot != 0) begin
                    granted = 1'b1;
                    g_edge  = k;
                    g_data  = shadow[pend_addr];
                    next_ok = k + 4;
                    chk("rnd_grant_addr", 32'(mem_addr), 32'(pend_addr));
                end else begin
                    exp_stall++;
                end
            end
            exp_ack = granted && (k == g_edge + 2);
            chk("rnd_vid_ack", 32'(vid_ack), 32'(exp_ack));
            if (exp_ack) chk("rnd_vid_data", 32'(vid_data), 32'(g_data));
            if (slot == 0) begin
                exp_we = op_we && !op_addr[15];
                chk("rnd_mem_we", 32'(mem_we), 32'(exp_we));
                chk("rnd_mem_addr", 32'(mem_addr), 32'(op_addr[14:0]));
                if (exp_we) chk("rnd_mem_wdata", 32'(mem_wdata), 32'(op_din));
            end else begin
                chk("rnd_mem_we_off", 32'(mem_we), 32'(0));
            end
            if (slot == 2 && !op_we)
                chk("rnd_cpu_rdata", 32'(cpu_data_out), 32'(shadow[op_addr[14:0]]));

            if (exp_ack) begin
                pend = 1'b0; granted = 1'b0; vid_req = 1'b0;
            end
            if (!pend && $urandom_range(0, 2) == 0) begin
                pend = 1'b1;
                pend_addr = 15'($urandom_range(0, 63));
                req_cyc = k;
                vid_req = 1'b1;
                vid_addr = pend_addr;
            end
            if (((k + 1) % S) == 0) begin
                op_we   = 1'($urandom_range(0, 1));
                op_addr = {1'($urandom_range(0, 3) == 0), 15'($urandom_range(0, 63))};
                op_din  = 8'($urandom);
                cpu_addr = op_addr; cpu_data_in = op_din; cpu_write_enable = op_we;
                if (op_we && !op_addr[15]) shadow[op_addr[14:0]] = op_din;
            end
        end
`ifdef MEM_ARB_STATS_EN
        chk("rnd_stall", 32'(vid_stall_count), 32'(exp_stall));
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
